// File: rtl/div_arbiter_if.sv
// Bundles the requester-side and divider-side signals of the shared-divider arbiter.
// The arbiter is the slave; the requesters and the divider together form the master side.
`timescale 1ns/1ps
interface div_arbiter_if #(
  parameter int n = 8,
  parameter int p = 8
);
  logic [3:0]     req;
  logic [4*n-1:0] x_in;
  logic [4*n-1:0] y_in;
  logic [3:0]     gnt;
  logic [3:0]     rsp_valid;
  logic [1:0]     rsp_id;
  logic [p-1:0]   rsp_quotient;
  logic [p-1:0]   rsp_remainder;
  logic           rsp_err;
  logic           div_rst;
  logic           div_start;
  logic [n-1:0]   div_x;
  logic [n-1:0]   div_y;
  logic           div_done;
  logic [p-1:0]   div_quotient;
  logic [p-1:0]   div_remainder;

  modport slave (
    input  req, x_in, y_in, div_done, div_quotient, div_remainder,
    output gnt, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
           div_rst, div_start, div_x, div_y
  );

  modport master (
    output req, x_in, y_in, div_done, div_quotient, div_remainder,
    input  gnt, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_err,
           div_rst, div_start, div_x, div_y
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among four requesters,
// with divide-by-zero bypass and a WAIT timeout. Every output is a register.
`timescale 1ns/1ps
module div_arbiter #(
  parameter int n   = 8,
  parameter int p   = 8,
  parameter int TMO = 2*p+4
) (
  input  logic         clk,
  input  logic         reset,
  div_arbiter_if.slave bus
);
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LAUNCH, S_WAIT, S_ZERO, S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_nextState;

  logic [1:0]    r_lastWinner;
  logic [1:0]    r_id;
  logic [1:0]    w_winner;
  logic [1:0]    w_cand;
  logic [n-1:0]  r_x;
  logic [n-1:0]  r_y;
  logic [n-1:0]  w_selX;
  logic [n-1:0]  w_selY;
  logic [CW-1:0] r_cnt;
  logic          w_timeout;
  logic [p-1:0]  w_zeroRem;

  logic [3:0]    r_gnt;
  logic [3:0]    r_rspValid;
  logic [1:0]    r_rspId;
  logic [p-1:0]  r_rspQuot;
  logic [p-1:0]  r_rspRem;
  logic          r_rspErr;
  logic          r_divRst;
  logic          r_divStart;

  // Scan downward so the requester closest after the last winner overwrites the rest.
  always_comb begin
    w_winner = r_lastWinner;
    w_cand   = r_lastWinner;
    for (int k = 4; k >= 1; k--) begin
      w_cand = r_lastWinner + 2'(k);
      if (bus.req[w_cand]) begin
        w_winner = w_cand;
      end
    end
  end

  assign w_selX    = bus.x_in[int'(w_winner)*n +: n];
  assign w_selY    = bus.y_in[int'(w_winner)*n +: n];
  assign w_timeout = (r_cnt == CW'(TMO - 1));

  generate
    if (p > n) begin : g_remExtend
      assign w_zeroRem = {{(p-n){r_x[n-1]}}, r_x};
    end else if (p == n) begin : g_remSame
      assign w_zeroRem = r_x;
    end else begin : g_remTrunc
      assign w_zeroRem = r_x[p-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (|bus.req) begin
          w_nextState = (w_selY == '0) ? S_ZERO : S_CLR;
        end
      end
      S_CLR:    w_nextState = S_LAUNCH;
      S_LAUNCH: w_nextState = S_WAIT;
      S_WAIT: begin
        if (bus.div_done || w_timeout) begin
          w_nextState = S_RESP;
        end
      end
      S_ZERO:   w_nextState = S_RESP;
      S_RESP:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Each output pulse is registered on the edge leaving the state that owns it,
  // so it is visible during the following state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lastWinner <= 2'd3;
      r_id         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_rspValid   <= '0;
      r_rspId      <= '0;
      r_rspQuot    <= '0;
      r_rspRem     <= '0;
      r_rspErr     <= 1'b0;
      r_divRst     <= 1'b1;
      r_divStart   <= 1'b0;
    end else begin
      r_gnt      <= '0;
      r_rspValid <= '0;
      r_divRst   <= (r_state == S_CLR);
      r_divStart <= (r_state == S_LAUNCH);
      unique case (r_state)
        S_IDLE: begin
          if (|bus.req) begin
            r_gnt        <= 4'b0001 << w_winner;
            r_x          <= w_selX;
            r_y          <= w_selY;
            r_id         <= w_winner;
            r_lastWinner <= w_winner;
          end
        end
        S_LAUNCH: begin
          r_cnt <= '0;
        end
        S_WAIT: begin
          if (bus.div_done) begin
            r_rspQuot <= bus.div_quotient;
            r_rspRem  <= bus.div_remainder;
            r_rspErr  <= 1'b0;
            r_rspId   <= r_id;
          end else if (w_timeout) begin
            r_rspQuot <= '0;
            r_rspRem  <= '0;
            r_rspErr  <= 1'b1;
            r_rspId   <= r_id;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_ZERO: begin
          r_rspQuot <= '1;
          r_rspRem  <= w_zeroRem;
          r_rspErr  <= 1'b1;
          r_rspId   <= r_id;
        end
        S_RESP: begin
          r_rspValid <= 4'b0001 << r_rspId;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.gnt           = r_gnt;
  assign bus.rsp_valid     = r_rspValid;
  assign bus.rsp_id        = r_rspId;
  assign bus.rsp_quotient  = r_rspQuot;
  assign bus.rsp_remainder = r_rspRem;
  assign bus.rsp_err       = r_rspErr;
  assign bus.div_rst       = r_divRst;
  assign bus.div_start     = r_divStart;
  assign bus.div_x         = r_x;
  assign bus.div_y         = r_y;
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter n, default 8: operand width of x/y, signed.
REQ-002 SHALL have parameter p, default 8: quotient/remainder width.
REQ-003 SHALL have parameter TMO, default 2*p+4: WAIT-state timeout in cycles.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port req  in  4  request per requester 0..3.
REQ-007 SHALL have port x_in  in  4*n  packed dividends; requester k at bits [k*n +: n].
REQ-008 SHALL have port y_in  in  4*n  packed divisors, same packing.
REQ-009 SHALL have port gnt  out  4  one-cycle one-hot grant; operands of the granted requester are captured at that edge.
REQ-010 SHALL have port rsp_valid  out  4  one-cycle one-hot result strobe.
REQ-011 SHALL have port rsp_id  out  2  index of the requester whose result is on rsp_quotient/rsp_remainder.
REQ-012 SHALL have port rsp_quotient, rsp_remainder  out  p each  result.
REQ-013 SHALL have port rsp_err  out  1  qualifies rsp_valid: divide-by-zero or timeout.
REQ-014 SHALL have port div_rst  out  1  reset pulse to the shared divider; clears its sticky done.
REQ-015 SHALL have port div_start  out  1  start pulse to the divider.
REQ-016 SHALL have port div_x, div_y  out  n each  operands to the divider, held stable from LAUNCH through WAIT.
REQ-017 SHALL have port div_done  in  1  divider done, level, sticky until div_rst.
REQ-018 SHALL have port div_quotient, div_remainder  in  p each  divider results.

Function
REQ-019 SHALL implement an FSM: IDLE, CLR, LAUNCH, WAIT, ZERO, RESP; all outputs registered.
REQ-020 In IDLE with req!=0, SHALL select a winner round-robin starting at (last_winner+1) mod 4, assert gnt[winner] for one cycle, capture x/y into internal registers, update last_winner.
REQ-021 If the captured y==0, SHALL go IDLE->ZERO, skip the divider entirely, and present rsp_quotient={p{1'b1}}, rsp_remainder=x sign-extended/truncated to p, rsp_err=1.
REQ-022 Otherwise IDLE->CLR: div_rst=1 for exactly one cycle; CLR->LAUNCH: div_start=1 for exactly one cycle; LAUNCH->WAIT.
REQ-023 In WAIT, an edge sampling div_done=1 SHALL capture div_quotient/div_remainder and go to RESP with rsp_err=0.
REQ-024 In WAIT, a cycle counter SHALL start at 0 on entry; if it reaches TMO without div_done, SHALL go to RESP with rsp_quotient=0, rsp_remainder=0, rsp_err=1.
REQ-025 ZERO->RESP and WAIT->RESP SHALL assert rsp_valid[id] and rsp_id for exactly one cycle; RESP->IDLE unconditionally.
REQ-026 Arbitration SHALL resume only in IDLE; requests arriving in other states SHALL wait, not be dropped, as long as req stays high.
REQ-027 A req still high in IDLE after its response SHALL be treated as a new request; the requester drops req after gnt for a single operation.
REQ-028 Latency gnt->div_start SHALL be exactly 2 cycles; div-by-zero gnt->rsp_valid exactly 2 cycles.
REQ-029 gnt, rsp_valid SHALL never have more than one bit set; gnt and rsp_valid never both nonzero.

Reset
REQ-030 reset high at an edge SHALL force IDLE from any state, including mid-WAIT, discarding the in-flight operation without a response.
REQ-031 Reset values: gnt=0, rsp_valid=0, rsp_id=0, rsp_quotient=0, rsp_remainder=0, rsp_err=0, div_start=0, div_x=0, div_y=0, div_rst=1, last_winner=3 (requester 0 wins first).
REQ-032 div_rst SHALL deassert on the first edge with reset low.

Verification
REQ-033 req=4'b0001, x=100, y=7, model divider done after 5 cycles -> gnt=0001, div_rst next cycle, div_start next, rsp_valid=0001, rsp_id=0, quotient 14, remainder 2, rsp_err=0.
REQ-034 req=4'b1111 held -> grant order 0,1,2,3,0; never two grants without an intervening RESP.
REQ-035 req=4'b0100, x=45, y=0 -> div_start never pulses; rsp_valid=0100 two cycles after gnt, quotient 8'hFF, remainder 45, rsp_err=1.
REQ-036 Divider model never asserts done -> rsp_valid after TMO WAIT cycles with rsp_err=1, quotient 0, remainder 0; next request served normally.
REQ-037 reset asserted mid-WAIT for requester 1 -> no rsp_valid, all outputs at reset values, next grant goes to requester 0.
REQ-038 req[2] asserted during WAIT of requester 1 -> served after RESP of requester 1, before requester 0.
